pwm_duty_gen: RTL and testbench

//  Consumes the VAL_BITS-wide sawtooth/ramp value as a duty command and drives a glitch-free PWM pin (LED dimming).

---
 rtl/pwm_duty_gen_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 35 +++
 rtl/pwm_duty_gen.sv | 134 +++++++++++++
 tb/tb_pwm_duty_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_gen_pkg.sv
// Shared types for the PWM duty generator:
// carrier direction states and carrier mode encodings.
package pwm_duty_gen_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every PRE_DIV
// enabled clocks; held at zero while disabled.
module pwm_prescaler #(
  parameter int PRE_DIV  = 1,
  parameter int PRE_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_BITS-1:0] LAST = PRE_BITS'(PRE_DIV - 1);

  logic [PRE_BITS-1:0] pre_q;
  logic [PRE_BITS-1:0] pre_d;

  assign tick = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (!en || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_duty_gen.sv
// Double-buffered PWM generator with edge- or
// center-aligned carrier and clock prescaler.
module pwm_duty_gen
  import pwm_duty_gen_pkg::*;
#(
  parameter int VAL_BITS = 7,
  parameter int PRE_DIV  = 1,
  parameter int PRE_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                center,
  input  logic [VAL_BITS-1:0] duty,
  input  logic                duty_load,
  output logic                pwm,
  output logic                period_strb,
  output logic [VAL_BITS-1:0] duty_act
);

  localparam logic [VAL_BITS-1:0] MAX = {VAL_BITS{1'b1}};
  localparam logic [VAL_BITS-1:0] ONE = VAL_BITS'(1);

  logic                tick;
  logic                bnd;
  logic [VAL_BITS-1:0] cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic                mode_q, mode_d;
  logic [VAL_BITS-1:0] duty_q, duty_d;
  logic [VAL_BITS-1:0] pend_q, pend_d;
  logic                pvld_q, pvld_d;
  logic                pwm_q, pwm_d;
  logic                strb_q, strb_d;

  logic is_edge;
  logic c_top;
  logic c_up;
  logic c_dn;

  pwm_prescaler #(
    .PRE_DIV  (PRE_DIV),
    .PRE_BITS (PRE_BITS)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign is_edge = (mode_q == MODE_EDGE);
  assign c_top   = !is_edge && (dir_q == DIR_UP) && (cnt_q == MAX);
  assign c_up    = !is_edge && (dir_q == DIR_UP) && (cnt_q != MAX);
  assign c_dn    = !is_edge && (dir_q == DIR_DOWN);

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    duty_d = duty_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    pwm_d  = en && (cnt_q < duty_q);
    bnd    = 1'b0;

    if (tick) begin
      bnd = is_edge ? (cnt_q == MAX) : (c_dn && cnt_q == '0);
    end
    strb_d = bnd;

    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (bnd) begin
      // a continuing center carrier skips the repeated zero
      mode_d = center;
      dir_d  = DIR_UP;
      if (!is_edge && center == MODE_CENTER) begin
        cnt_d = ONE;
      end else begin
        cnt_d = '0;
      end
    end else if (tick) begin
      unique case (1'b1)
        is_edge: cnt_d = cnt_q + 1'b1;
        c_top: begin
          cnt_d = MAX - 1'b1;
          dir_d = DIR_DOWN;
        end
        c_up: cnt_d = cnt_q + 1'b1;
        c_dn: cnt_d = cnt_q - 1'b1;
      endcase
    end

    if (bnd) begin
      pvld_d = 1'b0;
      if (duty_load) begin
        duty_d = duty;
        pend_d = duty;
      end else if (pvld_q) begin
        duty_d = pend_q;
      end
    end else if (duty_load) begin
      pend_d = duty;
      pvld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_EDGE;
      duty_q <= '0;
      pend_q <= '0;
      pvld_q <= 1'b0;
      pwm_q  <= 1'b0;
      strb_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      duty_q <= duty_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      pwm_q  <= pwm_d;
      strb_q <= strb_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_strb = strb_q;
  assign duty_act    = duty_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: PRE_DIV=1 and PRE_DIV=4
// instances against a phase-based reference model.
module tb_pwm_duty_gen;

  localparam int MAX = 127;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       center;
  logic [6:0] duty;
  logic       duty_load;
  logic       pwm1, strb1, pwm2, strb2;
  logic [6:0] da1, da2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_duty_gen #(.VAL_BITS(7), .PRE_DIV(1), .PRE_BITS(16)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .duty(duty), .duty_load(duty_load),
    .pwm(pwm1), .period_strb(strb1), .duty_act(da1)
  );

  pwm_duty_gen #(.VAL_BITS(7), .PRE_DIV(4), .PRE_BITS(16)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .duty(duty), .duty_load(duty_load),
    .pwm(pwm2), .period_strb(strb2), .duty_act(da2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  // reference model: carrier as a phase position within the period
  int pd[2] = '{1, 4};
  int m_ph[2], m_pre[2], m_da[2], m_pend[2];
  bit m_mode[2], m_pv[2], m_pwm[2], m_strb[2];

  function automatic int cnt_of(input bit mode, input int ph);
    if (!mode) return ph;
    return (ph <= MAX) ? ph : 2 * MAX - ph;
  endfunction

  task automatic model_step(input int k);
    bit tk;
    bit bnd;
    if (rst) begin
      m_ph[k] = 0; m_pre[k] = 0; m_mode[k] = 0; m_da[k] = 0;
      m_pend[k] = 0; m_pv[k] = 0; m_pwm[k] = 0; m_strb[k] = 0;
    end else begin
      m_pwm[k] = en && (cnt_of(m_mode[k], m_ph[k]) < m_da[k]);
      tk = en && (m_pre[k] == pd[k] - 1);
      bnd = tk && (m_ph[k] == (m_mode[k] ? 2 * MAX : MAX));
      m_strb[k] = bnd;
      if (!en) begin
        m_ph[k] = 0;
        m_pre[k] = 0;
      end else begin
        m_pre[k] = tk ? 0 : m_pre[k] + 1;
        if (bnd) begin
          m_ph[k] = (m_mode[k] && center) ? 1 : 0;
          m_mode[k] = center;
        end else if (tk) begin
          m_ph[k]++;
        end
      end
      if (bnd) begin
        if (duty_load) m_da[k] = duty;
        else if (m_pv[k]) m_da[k] = m_pend[k];
        m_pv[k] = 0;
      end else if (duty_load) begin
        m_pend[k] = duty;
        m_pv[k] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    chk("m_pwm1", pwm1, m_pwm[0]);
    chk("m_strb1", strb1, m_strb[0]);
    chk("m_da1", da1, m_da[0]);
    chk("m_pwm4", pwm2, m_pwm[1]);
    chk("m_strb4", strb2, m_strb[1]);
    chk("m_da4", da2, m_da[1]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    duty = 7'(d);
    duty_load = 1'b1;
    cyc();
    duty_load = 1'b0;
  endtask

  task automatic wait_strb(input int which, input int lim);
    int n;
    bit s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = which ? strb2 : strb1;
    end while (!s && n < lim);
    chk("strobe_wait", s, 1);
  endtask

  task automatic measure(input int which, output int span, output int highs);
    bit s;
    span = 0;
    highs = 0;
    do begin
      highs += which ? int'(pwm2) : int'(pwm1);
      @(negedge clk);
      span++;
      s = which ? strb2 : strb1;
    end while (!s && span < 3000);
  endtask

  typedef struct {
    logic       center;
    logic [6:0] duty;
    int         period;
    int         high;
  } vec_t;

  vec_t vt[8];

  initial begin
    int sp, hi, n;

    vt[0] = '{1'b0, 7'd32, 128, 32};
    vt[1] = '{1'b0, 7'd0, 128, 0};
    vt[2] = '{1'b0, 7'd127, 128, 127};
    vt[3] = '{1'b0, 7'd1, 128, 1};
    vt[4] = '{1'b1, 7'd64, 254, 127};
    vt[5] = '{1'b1, 7'd127, 254, 253};
    vt[6] = '{1'b1, 7'd1, 254, 1};
    vt[7] = '{1'b1, 7'd0, 254, 0};

    rst = 1'b1; en = 1'b1; center = 1'b0; duty = '0; duty_load = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_pwm", pwm1, 0);
      chk("rst_da", da1, 0);
      chk("rst_strb", strb1, 0);
    end
    cyc();
    rst = 1'b0;

    load(32);
    wait_strb(0, 300);
    wait_strb(0, 300);
    repeat (20) cyc();
    load(96);
    repeat (10) cyc();
    load(64);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!strb1) chk("shadow_hold", da1, 32);
    end while (!strb1 && n < 300);
    chk("shadow_new", da1, 64);

    for (int i = 0; i < 8; i++) begin
      cyc();
      center = vt[i].center;
      load(vt[i].duty);
      wait_strb(0, 1000);
      wait_strb(0, 1000);
      measure(0, sp, hi);
      chk("tbl_period", sp, vt[i].period);
      chk("tbl_high", hi, vt[i].high);
    end

    repeat (253) cyc();
    load(100);
    @(negedge clk);
    chk("coin_strb", strb1, 1);
    chk("coin_da", da1, 100);

    cyc();
    center = 1'b0;
    wait_strb(1, 3000);
    wait_strb(1, 3000);
    measure(1, sp, hi);
    chk("pd4_period", sp, 512);
    chk("pd4_high", hi, 400);

    wait_strb(0, 300);
    repeat (10) cyc();
    en = 1'b0;
    @(negedge clk);
    chk("drop_before", pwm1, 1);
    cyc();
    @(negedge clk);
    chk("drop_pwm1", pwm1, 0);
    chk("drop_pwm4", pwm2, 0);
    repeat (4) begin
      cyc();
      @(negedge clk);
      chk("drop_strb", strb1, 0);
    end
    cyc();
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strb1 && n < 400);
    chk("restart_span", n, 129);

    repeat (30) cyc();
    load(50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_da", da1, 0);
    wait_strb(0, 300);
    chk("rst_discard", da1, 0);
    measure(0, sp, hi);
    chk("rst_high", hi, 0);
    chk("rst_period", sp, 128);

    repeat (4000) begin
      cyc();
      rst = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 299) == 0) center = ~center;
      duty_load = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0: duty = 7'd0;
        1: duty = 7'd127;
        default: duty = 7'($urandom_range(0, 127));
      endcase
    end
    cyc();
    duty_load = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
